// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by the fetch top and its buffer slot.
package instr_fetch_unit_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    STALE
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(
    input logic [INSTR_W-1:0] i
  );
    return i[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_slot.sv
// One instruction holding register: valid bit, data and PC.
// Used for both the instruction register and the prefetch buffer.
module fetch_buf_slot
  import instr_fetch_unit_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] load_pc,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] pc
);

  // clear drops only the valid bit so data holds for observers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: imem req/ack master, instruction register and
// one-entry prefetch buffer, with redirect on retirement.
module instr_fetch_unit #(
  parameter int ADDR_W  = instr_fetch_unit_pkg::ADDR_W,
  parameter int INSTR_W = instr_fetch_unit_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  import instr_fetch_unit_pkg::*;

  fetch_state_t state, state_nxt;

  logic [ADDR_W-1:0]  fa, fa_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;
  logic               ir_valid, pb_valid;
  logic [INSTR_W-1:0] ir_data, pb_data;
  logic [ADDR_W-1:0]  ir_pc, pb_pc;
  logic               retire, redir, ack_keep;
  logic               ir_load, ir_clear;
  logic               pb_load, pb_clear;
  logic               pb_valid_nxt, issue;
  logic [INSTR_W-1:0] ir_load_data;
  logic [ADDR_W-1:0]  ir_load_pc;

  assign retire   = ir_valid & instr_ready;
  assign redir    = retire & redirect;
  assign ack_keep = (state == BUSY) & imem_ack & ~redir;

  // IR is refilled from PB first so program order holds
  always_comb begin
    ir_load      = 1'b0;
    ir_clear     = 1'b0;
    pb_load      = 1'b0;
    pb_clear     = 1'b0;
    ir_load_data = imem_rdata;
    ir_load_pc   = addr;
    if (redir) begin
      ir_clear = 1'b1;
      pb_clear = 1'b1;
    end else if (retire) begin
      if (pb_valid) begin
        ir_load      = 1'b1;
        ir_load_data = pb_data;
        ir_load_pc   = pb_pc;
        pb_load      = ack_keep;
        pb_clear     = ~ack_keep;
      end else if (ack_keep) begin
        ir_load = 1'b1;
      end else begin
        ir_clear = 1'b1;
      end
    end else if (ack_keep) begin
      if (ir_valid) pb_load = 1'b1;
      else          ir_load = 1'b1;
    end
  end

  assign pb_valid_nxt = pb_load | (pb_valid & ~pb_clear);

  always_comb begin
    fa_nxt = fa;
    if (redir)         fa_nxt = redirect_pc;
    else if (ack_keep) fa_nxt = fa + ADDR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    issue     = 1'b0;
    unique case (state)
      IDLE: issue = ~pb_valid_nxt;
      BUSY: begin
        if (imem_ack) begin
          issue = ~pb_valid_nxt;
          if (pb_valid_nxt) state_nxt = IDLE;
        end else if (redir) begin
          state_nxt = STALE;
        end
      end
      STALE: if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      state_nxt = BUSY;
      addr_nxt  = fa_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fa    <= RESET_PC;
      addr  <= RESET_PC;
    end else begin
      state <= state_nxt;
      fa    <= fa_nxt;
      addr  <= addr_nxt;
    end
  end

  fetch_buf_slot #(.AW(ADDR_W), .DW(INSTR_W)) u_ir (
    .clk       (clk),
    .rst       (rst),
    .load      (ir_load),
    .clear     (ir_clear),
    .load_data (ir_load_data),
    .load_pc   (ir_load_pc),
    .valid     (ir_valid),
    .data      (ir_data),
    .pc        (ir_pc)
  );

  fetch_buf_slot #(.AW(ADDR_W), .DW(INSTR_W)) u_pb (
    .clk       (clk),
    .rst       (rst),
    .load      (pb_load),
    .clear     (pb_clear),
    .load_data (imem_rdata),
    .load_pc   (addr),
    .valid     (pb_valid),
    .data      (pb_data),
    .pc        (pb_pc)
  );

  assign imem_req    = (state != IDLE);
  assign imem_addr   = addr;
  assign instr       = ir_data;
  assign instr_valid = ir_valid;
  assign instr_pc    = ir_pc;

endmodule
